// File: rtl/scan_sequencer_if.sv
// Control and decoder-drive signals of the scan sequencer, grouped for the
// controller (master) and the sequencer itself (slave).
interface scan_sequencer_if #(
  parameter int PRESCALE_W = 8
);
  // start and stop are single-cycle request pulses with no ready: start is
  // taken only while busy is low; stop and pause act only while busy is high.
  logic                  start;
  logic                  stop;
  logic                  pause;
  logic                  mode;
  logic                  dir;
  logic [PRESCALE_W-1:0] period;
  logic [3:0]            cycles;
  logic [3:0]            binary_out;
  logic                  enable_out;
  logic                  busy;
  logic                  done;
  logic                  wrap_pulse;
  logic [1:0]            state_dbg;

  modport master (
    output start, stop, pause, mode, dir, period, cycles,
    input  binary_out, enable_out, busy, done, wrap_pulse, state_dbg
  );

  modport slave (
    input  start, stop, pause, mode, dir, period, cycles,
    output binary_out, enable_out, busy, done, wrap_pulse, state_dbg
  );
endinterface

// File: rtl/scan_sequencer.sv
// Steps a 4-bit index for a 4x16 decoder at a programmable rate, in wrap or
// ping-pong order, for a fixed number of passes or continuously.
module scan_sequencer #(
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  scan_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                state_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] period_q;
  logic [3:0]            cycles_q;
  logic [3:0]            pass_q;
  logic                  mode_q;
  logic                  down_q;
  logic [3:0]            bin_q;
  logic                  en_q;
  logic                  done_q;
  logic                  wrap_q;

  logic tick;
  logic at_term;
  logic last_pass;

  assign tick      = (presc_q == period_q);
  assign at_term   = down_q ? (bin_q == 4'd0) : (bin_q == 4'd15);
  assign last_pass = (cycles_q != 4'd0) && (pass_q == cycles_q - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      period_q <= '0;
      cycles_q <= '0;
      pass_q   <= '0;
      mode_q   <= 1'b0;
      down_q   <= 1'b0;
      bin_q    <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= RUN;
            presc_q  <= '0;
            pass_q   <= '0;
            period_q <= bus.period;
            cycles_q <= bus.cycles;
            mode_q   <= bus.mode;
            down_q   <= bus.dir;
            bin_q    <= bus.dir ? 4'd15 : 4'd0;
            en_q     <= 1'b1;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
          end else begin
            // The cycle that samples pause still steps; freezing starts in PAUSE.
            if (bus.pause) state_q <= PAUSE;
            if (!tick) begin
              presc_q <= presc_q + PRESCALE_W'(1);
            end else begin
              presc_q <= '0;
              if (!at_term) begin
                bin_q <= down_q ? bin_q - 4'd1 : bin_q + 4'd1;
              end else begin
                wrap_q <= 1'b1;
                if (last_pass) begin
                  // Finishing overrides a pending pause; index stays terminal.
                  state_q <= IDLE;
                  en_q    <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  pass_q <= pass_q + 4'd1;
                  if (mode_q) begin
                    down_q <= ~down_q;
                    bin_q  <= down_q ? 4'd1 : 4'd14;
                  end else begin
                    bin_q  <= down_q ? 4'd15 : 4'd0;
                  end
                end
              end
            end
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
          end else if (!bus.pause) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.binary_out = bin_q;
  assign bus.enable_out = en_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: each task drives one scenario and checks
// the packed status {busy, enable_out, done, wrap_pulse, binary_out} inline.
module tb_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  scan_sequencer_if #(.PRESCALE_W(8)) sif ();

  scan_sequencer #(.PRESCALE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  // status byte: {busy, enable_out, done, wrap_pulse, binary_out[3:0]}
  function automatic logic [7:0] st();
    return {sif.busy, sif.enable_out, sif.done, sif.wrap_pulse, sif.binary_out};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic m, input logic d, input logic [7:0] p,
                             input logic [3:0] c);
    sif.mode   = m;
    sif.dir    = d;
    sif.period = p;
    sif.cycles = c;
    sif.start  = 1'b1;
    step();
    sif.start  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    sif.start  = 1'b0;
    sif.stop   = 1'b0;
    sif.pause  = 1'b0;
    sif.mode   = 1'b0;
    sif.dir    = 1'b0;
    sif.period = 8'd0;
    sif.cycles = 4'd0;
    repeat (3) step();
    n_checks++;
    if (st() !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", st(), 8'h00);
    end
    n_checks++;
    if (sif.state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", sif.state_dbg);
    end
    rst_n = 1'b1;
    repeat (2) step();
    n_checks++;
    if (st() !== 8'h00) begin
      n_fail++; $display("FAIL reset_release_idle: got %h expected %h", st(), 8'h00);
    end
  endtask

  task automatic test_wrap_up_single();
    drive_start(1'b0, 1'b0, 8'd0, 4'd1);
    // later input changes must not disturb the latched configuration
    sif.period = 8'd7;
    sif.mode   = 1'b1;
    n_checks++;
    if (st() !== 8'hC0) begin
      n_fail++; $display("FAIL single_first: got %h expected %h", st(), 8'hC0);
    end
    for (int i = 1; i < 16; i++) begin
      step();
      n_checks++;
      if (st() !== {4'b1100, 4'(i)}) begin
        n_fail++; $display("FAIL single_idx%0d: got %h expected %h", i, st(), {4'b1100, 4'(i)});
      end
    end
    step();
    n_checks++;
    if (st() !== 8'h3F) begin
      n_fail++; $display("FAIL single_done: got %h expected %h", st(), 8'h3F);
    end
    step();
    n_checks++;
    if (st() !== 8'h0F) begin
      n_fail++; $display("FAIL single_after_done: got %h expected %h", st(), 8'h0F);
    end
  endtask

  task automatic test_pingpong();
    logic [3:0] cur;
    logic       up;
    logic       ew;
    cur = 4'd0;
    up  = 1'b1;
    drive_start(1'b1, 1'b0, 8'd3, 4'd2);
    for (int s = 1; s <= 30; s++) begin
      repeat (3) begin
        step();
        n_checks++;
        if (st() !== {4'b1100, cur}) begin
          n_fail++; $display("FAIL pp_hold_s%0d: got %h expected %h", s, st(), {4'b1100, cur});
        end
      end
      step();
      ew = up && (cur == 4'd15);
      if (ew) begin
        cur = 4'd14;
        up  = 1'b0;
      end else begin
        cur = up ? cur + 4'd1 : cur - 4'd1;
      end
      n_checks++;
      if (st() !== {3'b110, ew, cur}) begin
        n_fail++; $display("FAIL pp_step_s%0d: got %h expected %h", s, st(), {3'b110, ew, cur});
      end
    end
    repeat (3) step();
    step();
    n_checks++;
    if (st() !== 8'h30) begin
      n_fail++; $display("FAIL pp_done: got %h expected %h", st(), 8'h30);
    end
    step();
    n_checks++;
    if (st() !== 8'h00) begin
      n_fail++; $display("FAIL pp_after_done: got %h expected %h", st(), 8'h00);
    end
  endtask

  task automatic test_pause();
    drive_start(1'b0, 1'b0, 8'd3, 4'd0);
    repeat (22) step();
    n_checks++;
    if (st() !== 8'hC5) begin
      n_fail++; $display("FAIL pause_setup: got %h expected %h", st(), 8'hC5);
    end
    sif.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (st() !== 8'hC5) begin
        n_fail++; $display("FAIL pause_hold%0d: got %h expected %h", i, st(), 8'hC5);
      end
    end
    n_checks++;
    if (sif.state_dbg !== 2'd2) begin
      n_fail++; $display("FAIL pause_state: got %0d expected 2", sif.state_dbg);
    end
    sif.pause = 1'b0;
    step();
    n_checks++;
    if (st() !== 8'hC5) begin
      n_fail++; $display("FAIL pause_resume1: got %h expected %h", st(), 8'hC5);
    end
    step();
    n_checks++;
    if (st() !== 8'hC6) begin
      n_fail++; $display("FAIL pause_resume2: got %h expected %h", st(), 8'hC6);
    end
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    n_checks++;
    if (st() !== 8'h06) begin
      n_fail++; $display("FAIL pause_stop: got %h expected %h", st(), 8'h06);
    end
  endtask

  task automatic test_stop();
    drive_start(1'b0, 1'b0, 8'd0, 4'd0);
    repeat (4) step();
    n_checks++;
    if (st() !== 8'hC4) begin
      n_fail++; $display("FAIL stop_at4: got %h expected %h", st(), 8'hC4);
    end
    sif.start = 1'b1;
    sif.dir   = 1'b1;
    step();
    sif.start = 1'b0;
    n_checks++;
    if (st() !== 8'hC5) begin
      n_fail++; $display("FAIL stop_start_ignored: got %h expected %h", st(), 8'hC5);
    end
    repeat (4) step();
    n_checks++;
    if (st() !== 8'hC9) begin
      n_fail++; $display("FAIL stop_at9: got %h expected %h", st(), 8'hC9);
    end
    sif.stop = 1'b1;
    step();
    n_checks++;
    if (st() !== 8'h09) begin
      n_fail++; $display("FAIL stop_idle: got %h expected %h", st(), 8'h09);
    end
    sif.pause = 1'b1;
    step();
    n_checks++;
    if (st() !== 8'h09) begin
      n_fail++; $display("FAIL stop_idle_ignores: got %h expected %h", st(), 8'h09);
    end
    sif.stop  = 1'b0;
    sif.pause = 1'b0;
    sif.dir   = 1'b0;
  endtask

  task automatic test_continuous_down();
    logic [3:0] cur;
    logic       ew;
    int         wraps;
    cur   = 4'd15;
    wraps = 0;
    drive_start(1'b0, 1'b1, 8'd1, 4'd0);
    for (int s = 1; s <= 48; s++) begin
      step();
      n_checks++;
      if (st() !== {4'b1100, cur}) begin
        n_fail++; $display("FAIL cont_hold_s%0d: got %h expected %h", s, st(), {4'b1100, cur});
      end
      step();
      ew  = (cur == 4'd0);
      cur = cur - 4'd1;
      n_checks++;
      if (st() !== {3'b110, ew, cur}) begin
        n_fail++; $display("FAIL cont_step_s%0d: got %h expected %h", s, st(), {3'b110, ew, cur});
      end
      if (sif.wrap_pulse) wraps++;
    end
    n_checks++;
    if (wraps != 3) begin
      n_fail++; $display("FAIL cont_wrap_count: got %0d expected 3", wraps);
    end
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
    n_checks++;
    if (st() !== 8'h0F) begin
      n_fail++; $display("FAIL cont_stop: got %h expected %h", st(), 8'h0F);
    end
  endtask

  task automatic test_async_reset();
    drive_start(1'b0, 1'b0, 8'd0, 4'd0);
    repeat (5) step();
    n_checks++;
    if (st() !== 8'hC5) begin
      n_fail++; $display("FAIL areset_setup: got %h expected %h", st(), 8'hC5);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (st() !== 8'h00) begin
      n_fail++; $display("FAIL areset_immediate: got %h expected %h", st(), 8'h00);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) step();
    n_checks++;
    if (st() !== 8'h00) begin
      n_fail++; $display("FAIL areset_stays_idle: got %h expected %h", st(), 8'h00);
    end
    drive_start(1'b0, 1'b1, 8'd0, 4'd1);
    n_checks++;
    if (st() !== 8'hCF) begin
      n_fail++; $display("FAIL areset_restart: got %h expected %h", st(), 8'hCF);
    end
    step();
    n_checks++;
    if (st() !== 8'hCE) begin
      n_fail++; $display("FAIL areset_restart_step: got %h expected %h", st(), 8'hCE);
    end
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap_up_single();
    test_pingpong();
    test_pause();
    test_stop();
    test_continuous_down();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 8, width of the step-period input and prescaler counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  pulse that begins a sequence; sampled only in IDLE.
REQ-005 SHALL have port stop  input  1  pulse that aborts a sequence; sampled in RUN and PAUSE.
REQ-006 SHALL have port pause  input  1  level; freezes stepping while high.
REQ-007 SHALL have port mode  input  1  sequence mode: 0 = wrap, 1 = ping-pong.
REQ-008 SHALL have port dir  input  1  initial direction: 0 = up, 1 = down.
REQ-009 SHALL have port period  input  PRESCALE_W  number of clocks per step, minus 1.
REQ-010 SHALL have port cycles  input  4  passes to run before finishing; 0 = run continuously.
REQ-011 SHALL have port binary_out  output  4  registered index that drives the 4x16 decoder's binary input.
REQ-012 SHALL have port enable_out  output  1  registered enable that drives the 4x16 decoder's enable.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a finite sequence completes.
REQ-015 SHALL have port wrap_pulse  output  1  one-cycle pulse on each pass completion.

Function
REQ-016 SHALL implement the states IDLE, RUN and PAUSE.
REQ-017 SHALL sample mode, dir, period and cycles into internal registers on the start-accept edge and ignore later changes to them until the next start.
REQ-018 SHALL, on start=1 in IDLE, enter RUN on the next cycle with enable_out=1, binary_out=0 if dir=0 or 15 if dir=1, prescaler=0 and pass count=0.
REQ-019 SHALL issue a step tick when the prescaler equals the latched period, then clear the prescaler; otherwise the prescaler increments by 1 each cycle; period=0 gives a step on every cycle.
REQ-020 SHALL make the first step occur period+1 cycles after entering RUN.
REQ-021 SHALL, on a step, move binary_out by ±1 in the current direction.
REQ-022 SHALL treat the terminal index as 15 when moving up and 0 when moving down.
REQ-023 SHALL, in wrap mode, complete a pass on a step taken at the terminal index, and binary_out SHALL wrap 15→0 (up) or 0→15 (down).
REQ-024 SHALL, in ping-pong mode, complete a pass on a step taken at the terminal index, invert the direction, and move binary_out to 14 (from 15) or 1 (from 0).
REQ-025 SHALL assert wrap_pulse for exactly one cycle on each pass completion, in the same cycle the resulting index appears.
REQ-026 SHALL, when cycles≠0 and the completing pass is number cycles:
- go to IDLE
- hold binary_out at the terminal index
- set enable_out=0
- assert done and wrap_pulse for one cycle together
REQ-027 SHALL, when cycles=0, never finish and never assert done.
REQ-028 SHALL, while pause=1 in RUN, enter PAUSE next cycle; in PAUSE the prescaler and index are frozen and enable_out stays 1.
REQ-029 SHALL, on pause=0 in PAUSE, return to RUN with the prescaler continuing from its frozen value.
REQ-030 SHALL, on stop=1 in RUN or PAUSE, go to IDLE next cycle with enable_out=0, binary_out held and done=0.
REQ-031 SHALL give stop priority over pause and over a simultaneous step tick.
REQ-032 SHALL ignore start outside IDLE, and ignore stop and pause in IDLE.
REQ-033 SHALL have binary_out hold its last value in IDLE.

Reset
REQ-034 SHALL, on rst_n=0 and immediately without a clock, set:
- state=IDLE
- binary_out=0, enable_out=0
- busy=0, done=0, wrap_pulse=0
- prescaler, pass count and latched configuration registers to 0
REQ-035 SHALL remain in IDLE after rst_n deasserts until a start is accepted; reset mid-sequence SHALL abandon it with no done pulse.

Verification
REQ-036 SHALL cover: period=0, mode=0, dir=0, cycles=1, start → binary_out 0,1,…,15 on consecutive cycles with enable_out=1, then done=1 and wrap_pulse=1 for one cycle, enable_out=0, binary_out=15.
REQ-037 SHALL cover: period=3, mode=1, dir=0, cycles=2 → one step every 4 cycles 0…15, wrap_pulse, then 14…0, then done with binary_out=0.
REQ-038 SHALL cover: pause high for 10 cycles while binary_out=5 with prescaler=2 (period=3) → binary_out stays 5, enable_out=1, and the next step comes 2 cycles after pause falls.
REQ-039 SHALL cover: stop at binary_out=9, plus a start pulse during RUN → next cycle enable_out=0, binary_out=9, done=0, busy=0; the start has no effect.
REQ-040 SHALL cover: mode=0, dir=1, cycles=0, period=1 → sequence 15,14,…,0,15 with wrap_pulse on each 0→15 transition, and done never asserted over 3 passes.
REQ-041 SHALL cover: rst_n pulled low between clock edges mid-run → all outputs 0 before the next edge; after release, outputs stay idle until start.
